spike_frame_capture: RTL and testbench

- Conditions the 18 asynchronous neuron/comparator lines ahead of the 18-bit UART transmitter.
- Per channel: synchronizes, glitch-filters and rising-edge-detects each line, then ORs the spikes over one fixed window.
- At the end of each window, presents one stable 18-bit spike frame to the transmitter with a valid/ready handshake.
- The default window equals one UART frame time (20 bits × 576 clocks).

---
 rtl/spike_pkg.sv | 14 +
 rtl/spike_frame_capture_ch_filter.sv | 47 ++++
 rtl/spike_frame_capture.sv | 97 +++++++++
 tb/tb_spike_frame_capture.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/spike_pkg.sv
// Shared constants and types for the spike frame capture block.
package spike_pkg;

  localparam int unsigned N_CH_DEF        = 18;
  localparam int unsigned UART_BIT_CLKS   = 576;
  localparam int unsigned UART_FRAME_BITS = 20;
  localparam int unsigned WIN_DEF         = UART_BIT_CLKS * UART_FRAME_BITS;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/spike_frame_capture_ch_filter.sv
// One channel: 2-flop synchronizer, consecutive-mismatch glitch filter and
// rising-edge spike detect on the filtered level.
module ch_filter #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic sys_clk,
  input  logic sys_reset,
  input  logic ch_async,
  output logic spike_c
);

  localparam int unsigned CNT_W = $clog2(FILT_LEN);

  logic             sync_q1;
  logic             sync_q2;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mismatch_c;
  logic             flip_c;

  // The level flips on the FILT_LEN-th consecutive mismatch cycle.
  assign mismatch_c = sync_q2 ^ level_q;
  assign flip_c     = mismatch_c && (cnt_q == CNT_W'(FILT_LEN - 1));
  assign spike_c    = flip_c & sync_q2;

  // Synchronizer, mismatch counter and filtered level.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q1 <= ch_async;
      sync_q2 <= sync_q1;
      if (flip_c) begin
        level_q <= sync_q2;
        cnt_q   <= '0;
      end else if (mismatch_c) begin
        cnt_q   <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q   <= '0;
      end
    end
  end

endmodule

// File: rtl/spike_frame_capture.sv
// Filters N_CH async spike lines, ORs spikes over a fixed window and hands
// each completed window to the UART transmitter via valid/ready.
module spike_frame_capture
  import spike_pkg::*;
#(
  parameter int unsigned N_CH       = N_CH_DEF,
  parameter int unsigned FILT_LEN   = 4,
  parameter int unsigned WIN_CYCLES = WIN_DEF
) (
  input  logic            sys_clk,
  input  logic            sys_reset,
  input  logic            capture_en,
  input  logic [N_CH-1:0] ch_in,
  input  logic            frame_ready,
  output logic [N_CH-1:0] frame_data,
  output logic            frame_valid,
  output logic [7:0]      frame_seq,
  output logic            overflow
);

  localparam int unsigned WCNT_W = $clog2(WIN_CYCLES);

  state_e            state_q;
  state_e            state_d;
  logic [WCNT_W-1:0] win_cnt_q;
  logic [N_CH-1:0]   acc_q;
  logic [N_CH-1:0]   spike_c;
  logic              active_c;
  logic              win_end_c;
  logic              load_c;
  logic              xfer_c;

  // Per-channel conditioning.
  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    ch_filter #(
      .FILT_LEN (FILT_LEN)
    ) u_filt (
      .sys_clk   (sys_clk),
      .sys_reset (sys_reset),
      .ch_async  (ch_in[i]),
      .spike_c   (spike_c[i])
    );
  end

  // FSM state register.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next state plus window-end / load decisions; an exit edge discards the window.
  always_comb begin
    state_d   = state_q;
    active_c  = 1'b0;
    win_end_c = 1'b0;
    load_c    = 1'b0;
    xfer_c    = frame_valid & frame_ready;
    case (state_q)
      IDLE:    if (capture_en)  state_d = RUN;
      RUN:     if (!capture_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    active_c  = (state_q == RUN) && (state_d == RUN);
    win_end_c = active_c && (win_cnt_q == WCNT_W'(WIN_CYCLES - 1));
    load_c    = win_end_c && (!frame_valid || frame_ready);
  end

  // Window counter, accumulator, frame buffer and overflow flag.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      win_cnt_q   <= '0;
      acc_q       <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_seq   <= '0;
      overflow    <= 1'b0;
    end else begin
      if (!active_c || win_end_c) win_cnt_q <= '0;
      else                        win_cnt_q <= win_cnt_q + WCNT_W'(1);

      if (!active_c || load_c) acc_q <= '0;
      else                     acc_q <= acc_q | spike_c;

      if (load_c) begin
        frame_data  <= acc_q | spike_c;
        frame_valid <= 1'b1;
        frame_seq   <= frame_seq + 8'd1;
      end else if (xfer_c) begin
        frame_valid <= 1'b0;
      end

      if (state_q == IDLE)             overflow <= 1'b0;
      else if (win_end_c && !load_c)   overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spike_frame_capture.sv
// Directed bench for spike_frame_capture with a 64-cycle window.
module tb_spike_frame_capture;

  localparam int unsigned NCH = 18;
  localparam int unsigned FL  = 4;
  localparam int unsigned WC  = 64;

  logic           sys_clk = 1'b0;
  logic           sys_reset;
  logic           capture_en;
  logic [NCH-1:0] ch_in;
  logic           frame_ready;
  logic [NCH-1:0] frame_data;
  logic           frame_valid;
  logic [7:0]     frame_seq;
  logic           overflow;

  int n_chk  = 0;
  int n_pass = 0;
  int edge_n = 0;

  spike_frame_capture #(
    .N_CH       (NCH),
    .FILT_LEN   (FL),
    .WIN_CYCLES (WC)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_reset   (sys_reset),
    .capture_en  (capture_en),
    .ch_in       (ch_in),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_seq   (frame_seq),
    .overflow    (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  // Advance n edges; inputs are driven and outputs sampled 1 time unit after each edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
      edge_n++;
    end
  endtask

  task automatic goto(input int k);
    if (k > edge_n) step(k - edge_n);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reset, then enable capture so that the next edge is edge 0.
  task automatic restart(input logic rdy);
    sys_reset   = 1'b1;
    capture_en  = 1'b0;
    ch_in       = '0;
    frame_ready = rdy;
    step(2);
    sys_reset   = 1'b0;
    capture_en  = 1'b1;
    edge_n      = -1;
    step(1);
  endtask

  initial begin
    sys_reset = 1'b1; capture_en = 1'b0; ch_in = '0; frame_ready = 1'b0;
    step(2);
    check("rst_data",  32'(frame_data), 32'h0);
    check("rst_valid", 32'(frame_valid), 32'h0);
    check("rst_seq",   32'(frame_seq), 32'h0);
    check("rst_ovf",   32'(overflow), 32'h0);

    // Single spike on ch 3
    restart(1'b1);
    goto(4);  ch_in[3] = 1'b1;
    goto(14); ch_in[3] = 1'b0;
    goto(63); check("t1_valid_63", 32'(frame_valid), 32'h0);
    goto(64); check("t1_valid_64", 32'(frame_valid), 32'h1);
              check("t1_data",     32'(frame_data), 32'h00008);
              check("t1_seq",      32'(frame_seq), 32'h1);
    goto(65); check("t1_valid_65", 32'(frame_valid), 32'h0);

    // Glitch rejection: 3-cycle pulses dropped, 4-cycle pulse kept
    restart(1'b1);
    goto(4);  ch_in[0] = 1'b1;
    goto(7);  ch_in[0] = 1'b0;
    goto(20); ch_in[0] = 1'b1;
    goto(23); ch_in[0] = 1'b0;
    goto(64); check("t2_valid1", 32'(frame_valid), 32'h1);
              check("t2_data1",  32'(frame_data), 32'h0);
    goto(70); ch_in[0] = 1'b1;
    goto(74); ch_in[0] = 1'b0;
    goto(128); check("t2_data2", 32'(frame_data), 32'h1);
               check("t2_seq2",  32'(frame_seq), 32'h2);

    // Backpressure and overflow
    restart(1'b0);
    goto(10); ch_in[1] = 1'b1;
    goto(18); ch_in[1] = 1'b0;
    goto(64); check("t3_data1", 32'(frame_data), 32'h00002);
              check("t3_ovf64", 32'(overflow), 32'h0);
    goto(80); ch_in[2] = 1'b1;
    goto(88); ch_in[2] = 1'b0;
    goto(127); check("t3_ovf127", 32'(overflow), 32'h0);
    goto(128); check("t3_ovf128", 32'(overflow), 32'h1);
               check("t3_hold_data", 32'(frame_data), 32'h00002);
               check("t3_hold_seq",  32'(frame_seq), 32'h1);
               check("t3_hold_vld",  32'(frame_valid), 32'h1);
    goto(140); ch_in[2] = 1'b1;
    goto(148); ch_in[2] = 1'b0;
    goto(150); frame_ready = 1'b1;
    goto(151); check("t3_xfer_vld", 32'(frame_valid), 32'h0);
               check("t3_ovf_sticky", 32'(overflow), 32'h1);
    goto(192); check("t3_vld2",  32'(frame_valid), 32'h1);
               check("t3_data2", 32'(frame_data), 32'h00004);
               check("t3_seq2",  32'(frame_seq), 32'h2);

    // Transfer and window end on the same edge
    restart(1'b0);
    goto(10); ch_in[5] = 1'b1;
    goto(18); ch_in[5] = 1'b0;
    goto(64); check("t4_data1", 32'(frame_data), 32'h00020);
    goto(80); ch_in[6] = 1'b1;
    goto(88); ch_in[6] = 1'b0;
    goto(127); frame_ready = 1'b1;
    goto(128); frame_ready = 1'b0;
               check("t4_vld",  32'(frame_valid), 32'h1);
               check("t4_data", 32'(frame_data), 32'h00040);
               check("t4_seq",  32'(frame_seq), 32'h2);
               check("t4_ovf",  32'(overflow), 32'h0);
    goto(129); check("t4_vld_hold", 32'(frame_valid), 32'h1);

    // Spike landing on the window-end edge
    restart(1'b1);
    goto(58); ch_in[17] = 1'b1;
    goto(63); check("t5_vld63", 32'(frame_valid), 32'h0);
    goto(64); check("t5_data1", 32'(frame_data), 32'h20000);
              check("t5_seq1",  32'(frame_seq), 32'h1);
    goto(68); ch_in[17] = 1'b0;
    goto(128); check("t5_vld2",  32'(frame_valid), 32'h1);
               check("t5_data2", 32'(frame_data), 32'h0);
               check("t5_seq2",  32'(frame_seq), 32'h2);

    // Reset mid-window with a pending frame and overflow set
    restart(1'b0);
    goto(10); ch_in[2] = 1'b1;
    goto(18); ch_in[2] = 1'b0;
    goto(128); check("t6_ovf", 32'(overflow), 32'h1);
    goto(167); sys_reset = 1'b1;
    goto(168); check("t6_rst_data", 32'(frame_data), 32'h0);
               check("t6_rst_vld",  32'(frame_valid), 32'h0);
               check("t6_rst_seq",  32'(frame_seq), 32'h0);
               check("t6_rst_ovf",  32'(overflow), 32'h0);
    sys_reset = 1'b0;

    // capture_en drop mid-window: no frame, overflow cleared, pending frame kept
    restart(1'b0);
    goto(10); ch_in[3] = 1'b1;
    goto(18); ch_in[3] = 1'b0;
    goto(128); check("t7_ovf", 32'(overflow), 32'h1);
    goto(140); ch_in[4] = 1'b1;
    goto(148); ch_in[4] = 1'b0;
    goto(150); capture_en = 1'b0;
    goto(152); check("t7_ovf_clr", 32'(overflow), 32'h0);
               check("t7_vld",     32'(frame_valid), 32'h1);
    goto(200); check("t7_data",    32'(frame_data), 32'h00008);
               check("t7_seq",     32'(frame_seq), 32'h1);
               frame_ready = 1'b1;
    goto(201); check("t7_vld_drop", 32'(frame_valid), 32'h0);
    goto(260); check("t7_no_frame", 32'(frame_valid), 32'h0);
               check("t7_seq_end",  32'(frame_seq), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
